// File: rtl/cmos_rgb_to_axis_pkg.sv
// Shared types for the CMOS pixel stream to AXI4-Stream video bridge.
// FIFO word layout is {beat_flags_t, tdata}, flags at the top.
package cmos_rgb_to_axis_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_VS  = 2'd0,
    ST_WAIT_END = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_e;

  typedef struct packed {
    logic tuser;
    logic tlast;
  } beat_flags_t;

  localparam int unsigned FLAGS_W     = $bits(beat_flags_t);
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/cmos_rgb_to_axis_sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with occupancy counter; full/empty are registered.
// A write while full is refused even if a read happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_ok_c, rd_ok_c;

  always_comb begin
    wr_ok_c  = wr_en & ~full_q;
    rd_ok_c  = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok_c);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok_c);
    cnt_d    = cnt_q + CW'(wr_ok_c) - CW'(rd_ok_c);
    full_d   = (cnt_d == CW'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= din;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cmos_rgb_to_axis.sv
// Repacks a clock-enabled hs/vs/rgb pixel stream as AXI4-Stream video
// (tuser = start of frame, tlast = end of line) behind a backpressure FIFO.
module cmos_rgb_to_axis
  import cmos_rgb_to_axis_pkg::*;
#(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter bit          VS_ACT_HIGH = 1'b1
) (
  input  logic                   CLK_i,
  input  logic                   rst_n_i,
  input  logic                   vid_clk_ce,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic [DATA_W-1:0]      rgb_i,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   overflow_o,
  input  logic                   clr_i,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int unsigned WORD_W = FLAGS_W + DATA_W;

  state_e                 state_q, state_d;
  logic                   hold_vld_q, hold_vld_d;
  logic                   hold_tuser_q, hold_tuser_d;
  logic [DATA_W-1:0]      hold_pix_q, hold_pix_d;
  logic                   sof_pend_q, sof_pend_d;
  logic                   frame_clean_q, frame_clean_d;
  logic                   overflow_q, overflow_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   vs_act_c;
  logic                   wr_req_c;
  logic                   cnt_req_c;
  logic                   drop_c;
  beat_flags_t            wr_flags_c;
  beat_flags_t            rd_flags_c;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WORD_W-1:0]      fifo_dout;

  assign vs_act_c = VS_ACT_HIGH ? vs_i : ~vs_i;

  // Frame sync FSM plus one-pixel hold register; the held pixel is written
  // only once the next sample tells whether it ends the line.
  always_comb begin
    state_d          = state_q;
    hold_vld_d       = hold_vld_q;
    hold_tuser_d     = hold_tuser_q;
    hold_pix_d       = hold_pix_q;
    sof_pend_d       = sof_pend_q;
    frame_clean_d    = frame_clean_q;
    overflow_d       = overflow_q;
    frame_cnt_d      = frame_cnt_q;
    wr_req_c         = 1'b0;
    cnt_req_c        = 1'b0;
    wr_flags_c.tuser = hold_tuser_q;
    wr_flags_c.tlast = 1'b0;

    if (vid_clk_ce) begin
      unique case (state_q)
        ST_WAIT_VS: begin
          if (vs_act_c) state_d = ST_WAIT_END;
        end
        ST_WAIT_END: begin
          if (!vs_act_c) begin
            state_d    = ST_ACTIVE;
            sof_pend_d = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (vs_act_c) begin
            state_d          = ST_WAIT_END;
            wr_req_c         = hold_vld_q;
            wr_flags_c.tlast = 1'b1;
            hold_vld_d       = 1'b0;
            cnt_req_c        = frame_clean_q;
          end else if (hs_i) begin
            wr_req_c     = hold_vld_q;
            hold_vld_d   = 1'b1;
            hold_tuser_d = sof_pend_q;
            hold_pix_d   = rgb_i;
            sof_pend_d   = 1'b0;
            if (sof_pend_q) frame_clean_d = 1'b1;
          end else begin
            wr_req_c         = hold_vld_q;
            wr_flags_c.tlast = 1'b1;
            hold_vld_d       = 1'b0;
          end
        end
        default: state_d = ST_WAIT_VS;
      endcase
    end

    drop_c = wr_req_c & fifo_full;

    if (clr_i) overflow_d = 1'b0;

    // A refused write kills the rest of the frame; set beats clear.
    if (drop_c) begin
      overflow_d    = 1'b1;
      hold_vld_d    = 1'b0;
      frame_clean_d = 1'b0;
      state_d       = ST_WAIT_VS;
    end else if (cnt_req_c) begin
      frame_cnt_d   = frame_cnt_q + FRAME_CNT_W'(1);
      frame_clean_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_WAIT_VS;
      hold_vld_q    <= 1'b0;
      hold_tuser_q  <= 1'b0;
      hold_pix_q    <= '0;
      sof_pend_q    <= 1'b0;
      frame_clean_q <= 1'b0;
      overflow_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_vld_q    <= hold_vld_d;
      hold_tuser_q  <= hold_tuser_d;
      hold_pix_q    <= hold_pix_d;
      sof_pend_q    <= sof_pend_d;
      frame_clean_q <= frame_clean_d;
      overflow_q    <= overflow_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_i),
    .rst_n (rst_n_i),
    .wr_en (wr_req_c),
    .din   ({wr_flags_c, hold_pix_q}),
    .full  (fifo_full),
    .rd_en (m_axis_tvalid & m_axis_tready),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rd_flags_c    = fifo_dout[WORD_W-1 -: FLAGS_W];
  assign m_axis_tdata  = fifo_dout[DATA_W-1:0];
  assign m_axis_tuser  = rd_flags_c.tuser;
  assign m_axis_tlast  = rd_flags_c.tlast;
  assign m_axis_tvalid = ~fifo_empty;
  assign overflow_o    = overflow_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
